// File: rtl/des_f_pipe.sv
// Pipelined DES round function f(R,K) = P(S(E(R) xor K)) with valid/ready handshakes.
// Config macro DES_F_PIPE_STAGEB_REG_EN: registers the S/P stage (latency 2); undefined gives latency 1.
module des_f_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inValid,
  output logic        inReady,
  input  logic [31:0] rightHalf,
  input  logic [31:0] leftHalf,
  input  logic [47:0] subKey,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] fOutput,
  output logic [31:0] leftHalfOut,
  output logic [31:0] rightHalfOut
);

  // S1..S8, each 64 entries of 4 bits in reading order (row-major, row 0 first).
  localparam logic [2047:0] sbox_tbl = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // P permutation: output bit k (DES numbering) takes input bit p_tbl[k].
  localparam logic [255:0] p_tbl = {
    8'd16, 8'd7,  8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17,
    8'd1,  8'd15, 8'd23, 8'd26, 8'd5,  8'd18, 8'd31, 8'd10,
    8'd2,  8'd8,  8'd24, 8'd14, 8'd32, 8'd27, 8'd3,  8'd9,
    8'd19, 8'd13, 8'd30, 8'd6,  8'd22, 8'd11, 8'd4,  8'd25
  };

  // E: group j takes DES bits 4j..4j+5 of R, wrapping 0 -> 32 and 33 -> 1.
  function automatic logic [47:0] f_expand(input logic [31:0] r);
    logic [47:0] e;
    e = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      for (int unsigned m = 0; m < 6; m++) begin
        e[47 - 6*j - m] = r[31 - ((4*j + m + 31) % 32)];
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] f_subst(input logic [47:0] x);
    logic [31:0]  s;
    logic [5:0]   six;
    int unsigned  idx;
    s = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      six = x[47 - 6*j -: 6];
      idx = {26'd0, six[5], six[0], six[4:1]};
      s[31 - 4*j -: 4] = sbox_tbl[2047 - 256*j - 4*idx -: 4];
    end
    return s;
  endfunction

  function automatic logic [31:0] f_perm(input logic [31:0] s);
    logic [31:0] p;
    int unsigned src;
    p = '0;
    for (int unsigned k = 0; k < 32; k++) begin
      src = {24'd0, p_tbl[255 - 8*k -: 8]};
      p[31 - k] = s[32 - src];
    end
    return p;
  endfunction

  logic        va;
  logic [47:0] xa;
  logic [31:0] la;
  logic [31:0] ra;
  logic [31:0] f_comb;
  logic        a_free;

  assign f_comb  = f_perm(f_subst(xa));
  assign inReady = rst_n && a_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va <= 1'b0;
      xa <= '0;
      la <= '0;
      ra <= '0;
    end else if (a_free) begin
      va <= inValid;
      if (inValid) begin
        xa <= f_expand(rightHalf) ^ subKey;
        la <= leftHalf;
        ra <= rightHalf;
      end
    end
  end

`ifdef DES_F_PIPE_STAGEB_REG_EN
  logic        vb;
  logic [31:0] fb;
  logic [31:0] lb;
  logic [31:0] rb;
  logic        b_free;

  assign b_free = !vb || outReady;
  assign a_free = !va || b_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vb <= 1'b0;
      fb <= '0;
      lb <= '0;
      rb <= '0;
    end else if (b_free) begin
      vb <= va;
      if (va) begin
        fb <= f_comb;
        lb <= la;
        rb <= ra;
      end
    end
  end

  assign outValid     = vb;
  assign fOutput      = fb;
  assign leftHalfOut  = lb;
  assign rightHalfOut = rb;
`else
  assign a_free = !va || outReady;

  // Gated so fOutput reads 0 in reset rather than f of the cleared stage-A word.
  assign outValid     = va;
  assign fOutput      = va ? f_comb : '0;
  assign leftHalfOut  = la;
  assign rightHalfOut = ra;
`endif

endmodule

// File: tb/tb_des_f_pipe.sv
// Self-checking bench for des_f_pipe: directed FIPS/boundary cases plus randomized handshake traffic
// scored against a table-driven DES f model.
module tb_des_f_pipe;

`ifdef DES_F_PIPE_STAGEB_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam int E_TAB [48] = '{
    32, 1, 2, 3, 4, 5,    4, 5, 6, 7, 8, 9,    8, 9,10,11,12,13,   12,13,14,15,16,17,
    16,17,18,19,20,21,   20,21,22,23,24,25,   24,25,26,27,28,29,   28,29,30,31,32, 1};

  localparam int P_TAB [32] = '{
    16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
     2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};

  localparam int S_TAB [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,   0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,  15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,   3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,  13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,  13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,   1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,  13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,   3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,  14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,  11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,  10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,   4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,  13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,   6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,   1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,   2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] rightHalf = '0;
  logic [31:0] leftHalf = '0;
  logic [47:0] subKey = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] fOutput;
  logic [31:0] leftHalfOut;
  logic [31:0] rightHalfOut;

  des_f_pipe dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .rightHalf(rightHalf), .leftHalf(leftHalf), .subKey(subKey),
    .outValid(outValid), .outReady(outReady), .fOutput(fOutput),
    .leftHalfOut(leftHalfOut), .rightHalfOut(rightHalfOut)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned emit_cnt = 0;
  logic [95:0] sb [$];
  logic        hold = 1'b0;
  logic [95:0] held;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] ref_e(input logic [31:0] r);
    logic [47:0] e;
    for (int i = 0; i < 48; i++) e[47 - i] = r[32 - E_TAB[i]];
    return e;
  endfunction

  function automatic logic [31:0] ref_s(input logic [47:0] x);
    logic [31:0] s;
    logic [5:0]  g;
    int row, col;
    for (int b = 0; b < 8; b++) begin
      g   = x[47 - 6*b -: 6];
      row = 2 * int'(g[5]) + int'(g[0]);
      col = int'(g[4:1]);
      s[31 - 4*b -: 4] = 4'(S_TAB[b][16*row + col]);
    end
    return s;
  endfunction

  function automatic logic [31:0] ref_p(input logic [31:0] s);
    logic [31:0] p;
    for (int i = 0; i < 32; i++) p[31 - i] = s[32 - P_TAB[i]];
    return p;
  endfunction

  function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
    return ref_p(ref_s(ref_e(r) ^ k));
  endfunction

  // Scoreboard and output-hold monitor; sampled mid-cycle, away from the rising edge.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", outValid, 1'b1);
        check("hold_data", {fOutput, leftHalfOut, rightHalfOut}, held);
      end
      if (outValid && outReady) begin
        emit_cnt++;
        if (sb.size() == 0) check("emit_spurious", 1'b1, 1'b0);
        else check("emit_data", {fOutput, leftHalfOut, rightHalfOut}, sb.pop_front());
      end
      if (inValid && inReady) sb.push_back({ref_f(rightHalf, subKey), leftHalf, rightHalf});
      hold = outValid && !outReady;
      held = {fOutput, leftHalfOut, rightHalfOut};
    end
  end

  task automatic rand_data();
    case ($urandom_range(0, 7))
      0:       rightHalf = '0;
      1:       rightHalf = '1;
      default: rightHalf = $urandom;
    endcase
    leftHalf = $urandom;
    subKey   = ($urandom_range(0, 7) == 0) ? 48'h0 : {16'($urandom), 32'($urandom)};
  endtask

  task automatic send(input logic [31:0] r, input logic [31:0] l, input logic [47:0] k);
    int unsigned n = 0;
    logic acc = 1'b0;
    inValid = 1'b1; rightHalf = r; leftHalf = l; subKey = k;
    while (!acc && n < 50) begin
      @(negedge clk); acc = inReady;
      @(posedge clk); #1; n++;
    end
    inValid = 1'b0;
    if (!acc) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_out(output int unsigned cyc);
    cyc = 1;
    while (!outValid && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic drain(input string tag);
    int unsigned n = 0;
    inValid = 1'b0; outReady = 1'b1;
    while ((outValid || sb.size() != 0) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check(tag, 96'(sb.size()), 96'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cyc, e0, drops, acc_cnt, stale, sent;
    logic acc;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_inready", inReady, 1'b0);
    check("rst_outvalid", outValid, 1'b0);
    check("rst_fout", fOutput, 32'h0);
    check("rst_lout", leftHalfOut, 32'h0);
    check("rst_rout", rightHalfOut, 32'h0);

    // FIPS round-1 vector, offered in the first cycle after reset release
    @(posedge clk); #1;
    rst_n = 1'b1; outReady = 1'b1;
    #1 check("first_ready", inReady, 1'b1);
    send(32'hF0AAF0AA, 32'hCC00CCFF, 48'h1B02EFFC7072);
    wait_out(cyc);
    check("fips_latency", 96'(cyc), 96'(LAT));
    check("fips_f", fOutput, 32'h234AA9BB);
    check("fips_l", leftHalfOut, 32'hCC00CCFF);
    check("fips_r", rightHalfOut, 32'hF0AAF0AA);
    drain("fips_drain");

    // Zero input
    send(32'h0, 32'h13572468, 48'h0);
    wait_out(cyc);
    check("zero_f_model", fOutput, ref_f(32'h0, 48'h0));
    check("zero_f_sbox", fOutput, ref_p(32'hEFA72C4D));
    drain("zero_drain");

    // Back-to-back stream of 16
    e0 = emit_cnt; drops = 0; outReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      inValid = 1'b1; rand_data();
      @(negedge clk); if (!inReady) drops++;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    check("b2b_count", 96'(emit_cnt - e0), 96'd16);
    check("b2b_inready_drops", 96'(drops), 96'd0);
    drain("b2b_drain");

    // Backpressure for 5 cycles
    e0 = emit_cnt; acc_cnt = 0; outReady = 1'b0; inValid = 1'b1; rand_data();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); acc = inReady; if (acc) acc_cnt++;
      @(posedge clk); #1;
      if (acc) rand_data();
    end
    check("bp_accepted", 96'(acc_cnt), 96'(LAT));
    check("bp_inready_full", inReady, 1'b0);
    check("bp_outvalid", outValid, 1'b1);
    drain("bp_drain");
    check("bp_emitted", 96'(emit_cnt - e0), 96'(LAT));

    // Reset with the pipe full
    outReady = 1'b0; inValid = 1'b1; rand_data();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); acc = inReady;
      @(posedge clk); #1;
      if (acc) rand_data();
    end
    inValid = 1'b0;
    check("inflight_valid", outValid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_outvalid", outValid, 1'b0);
    check("midrst_inready", inReady, 1'b0);
    check("midrst_fout", fOutput, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; outReady = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk); if (outValid) stale++;
    end
    check("midrst_no_stale", 96'(stale), 96'd0);

    // Random traffic
    @(posedge clk); #1;
    sent = 0; cyc = 0; acc = 1'b0; inValid = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      if (!inValid || acc) begin
        inValid = ($urandom_range(0, 9) < 7);
        rand_data();
      end
      outReady = ($urandom_range(0, 9) < 7);
      @(negedge clk); acc = inValid && inReady; if (acc) sent++;
      @(posedge clk); #1; cyc++;
    end
    check("rand_sent", 96'(sent), 96'd10000);
    drain("rand_drain");
    #1 check("final_outvalid", outValid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
